fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register of the 5-stage core. It owns the PC and issues requests to instruction memory. It applies the hazard unit's stall, flush and branch-taken controls and presents a fetched instruction with its PC to decode. It sits directly upstream of decode and the hazard unit, and consumes their `stall`, `flush2` and `branchTakenFlag` outputs.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; bits [1:0] must be 0.
- `NOP_INSTR`, default `32'h0000_0000`: word driven on `instr_IFID` while the IF/ID register is invalid.

Ports (reset is asynchronous and active-low):
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard stall; hold the PC and the IF/ID register.
- `flush`  in  1  hazard flush (flush2); invalidate the IF/ID register.
- `branchTakenFlag`  in  1  redirect the PC to `branchTarget`.
- `branchTarget`  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to the PC register.
- `imem_ready`  in  1  `imem_rdata` is valid this cycle for `imem_addr`.
- `imem_rdata`  in  32  instruction word.
- `pc_IFID`  out  32  PC of the instruction held in IF/ID.
- `instr_IFID`  out  32  instruction held in IF/ID.
- `valid_IFID`  out  1  IF/ID holds a real instruction.
- `stallCount`, `flushCount`  out  32 each  present only with `FETCH_PERF_CNT_EN`.

## Operation
- Registered state:
  - `pc`
  - FSM state: `BOOT`, `FETCH`, `HOLD`
  - 32-bit skid register and its valid bit
  - IF/ID register: pc, instr, valid
- Reset values:
  - `pc`=`RESET_PC`, state=`BOOT`, skid valid=0.
  - `valid_IFID`=0, `pc_IFID`=0, `instr_IFID`=`NOP_INSTR`, `imem_req`=0, counters=0.
- Priority, highest first: reset, `branchTakenFlag`, `flush`, `stall`, normal.
- `BOOT`:
  - `imem_req`=0 for one cycle, then go to `FETCH`.
  - `branchTakenFlag` in `BOOT` still loads the PC.
- `FETCH`:
  - `imem_req`=1.
  - `imem_ready` & !`stall` & !`flush`: IF/ID takes {`pc`, `imem_rdata`, valid=1}; `pc`<=`pc`+4.
  - `imem_ready` & `stall`: word goes to skid (skid valid=1); IF/ID held; go to `HOLD`.
  - !`imem_ready` & !`stall`: IF/ID valid<=0 (bubble); `pc` held.
  - !`imem_ready` & `stall`: everything held.
- `HOLD`:
  - `imem_req`=0.
  - While `stall`: everything held.
  - When `stall` drops: IF/ID takes {`pc`, skid, valid=1}; `pc`<=`pc`+4; skid valid<=0; go to `FETCH`.
- `branchTakenFlag` (any state):
  - `pc`<={`branchTarget`[31:2],2'b00}.
  - IF/ID valid<=0 and skid valid<=0; go to `FETCH`.
  - Any `imem_rdata` accepted that cycle is discarded.
- `flush` without `branchTakenFlag`:
  - IF/ID valid<=0.
  - A word returned that cycle is discarded and `pc` is not advanced; the same address is refetched.
- Arithmetic: `pc`+4 is modulo 2^32, so `32'hFFFF_FFFC` wraps to 0.
- `instr_IFID` outputs `NOP_INSTR` whenever `valid_IFID`=0; `pc_IFID` keeps its last value.

## Timing
- `imem_addr` and `imem_req` are decoded from registered state only; there is no combinational path from `imem_ready`.
- Reset release: cycle 0 is `BOOT`; first request in cycle 1; earliest `valid_IFID`=1 at the cycle 2 edge.
- Fetch latency: 1 cycle from `imem_ready` to `valid_IFID`. Throughput is 1 instruction per cycle with `imem_ready` held high.
- Redirect penalty: the first target instruction reaches IF/ID 2 edges after `branchTakenFlag` (1 bubble).
- Asynchronous reset mid-`HOLD` or mid-request: immediate return to reset values; the pending word is lost.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `stallCount` increments on each cycle with `stall`=1.
  - `flushCount` increments on each cycle with `flush`|`branchTakenFlag`=1.
  - Both saturate at `32'hFFFF_FFFF`; reset to 0.
- Not defined: the counters and their ports are absent; functional behaviour is identical.

## Test plan
- Reset with `RESET_PC`=0 and `imem_ready`=1, returning data=addr -> `imem_addr` sequence 0,4,8; `instr_IFID` 0,4,8 from the cycle 2 edge.
- `stall` high 3 cycles coinciding with a ready response at addr 8 -> `HOLD` entered, IF/ID holds addr 4 for 3 cycles, then presents 8 with `pc_IFID`=8 and no duplicate or loss.
- `branchTakenFlag` with `branchTarget`=`32'h0000_0103` during a fetch at 12 -> next `imem_addr`=`32'h100`; one `valid_IFID`=0 cycle; then `instr_IFID`=`32'h100`.
- `branchTakenFlag` and `stall` in the same `HOLD` cycle -> redirect wins, skid cleared, `imem_addr`=target next cycle.
- PC=`32'hFFFF_FFFC` accepted -> next `imem_addr`=0.
- `FETCH_PERF_CNT_EN`: 5 stall cycles and 2 flush cycles -> `stallCount`=5, `flushCount`=2; mid-run reset -> both 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, one-word skid buffer and IF/ID pipeline register.
// Optional stall/flush performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branchTakenFlag,
    input  logic [31:0] branchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_IFID,
    output logic [31:0] instr_IFID,
    output logic        valid_IFID
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
`endif
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } FetchState;

    FetchState   state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] skidWord, skidWordNext;
    logic        skidValid, skidValidNext;
    logic [31:0] ifidPc, ifidPcNext;
    logic [31:0] ifidInstr, ifidInstrNext;
    logic        ifidValid, ifidValidNext;

    logic [31:0] targetAligned;
    logic [31:0] pcPlus4;
    logic        unusedTargetBits;

    assign targetAligned    = {branchTarget[31:2], 2'b00};
    assign pcPlus4          = pc + 32'd4;
    assign unusedTargetBits = ^branchTarget[1:0];

    // State register for the FSM, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            skidWord  <= 32'd0;
            skidValid <= 1'b0;
            ifidPc    <= 32'd0;
            ifidInstr <= NOP_INSTR;
            ifidValid <= 1'b0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            skidWord  <= skidWordNext;
            skidValid <= skidValidNext;
            ifidPc    <= ifidPcNext;
            ifidInstr <= ifidInstrNext;
            ifidValid <= ifidValidNext;
        end
    end

    // Redirect beats flush beats stall; a word caught during a stall parks in the skid.
    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        skidWordNext  = skidWord;
        skidValidNext = skidValid;
        ifidPcNext    = ifidPc;
        ifidInstrNext = ifidInstr;
        ifidValidNext = ifidValid;

        if (branchTakenFlag) begin
            pcNext        = targetAligned;
            ifidValidNext = 1'b0;
            skidValidNext = 1'b0;
            stateNext     = FETCH;
        end else if (flush) begin
            ifidValidNext = 1'b0;
            skidValidNext = 1'b0;
            stateNext     = FETCH;
        end else begin
            case (state)
                BOOT: begin
                    stateNext = FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        if (stall) begin
                            skidWordNext  = imem_rdata;
                            skidValidNext = 1'b1;
                            stateNext     = HOLD;
                        end else begin
                            ifidPcNext    = pc;
                            ifidInstrNext = imem_rdata;
                            ifidValidNext = 1'b1;
                            pcNext        = pcPlus4;
                        end
                    end else if (!stall) begin
                        ifidValidNext = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifidPcNext    = pc;
                        ifidInstrNext = skidWord;
                        ifidValidNext = skidValid;
                        pcNext        = pcPlus4;
                        skidValidNext = 1'b0;
                        stateNext     = FETCH;
                    end
                end
                default: begin
                    stateNext = BOOT;
                end
            endcase
        end
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc;
    assign pc_IFID    = ifidPc;
    assign valid_IFID = ifidValid;
    assign instr_IFID = ifidValid ? ifidInstr : NOP_INSTR;

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters; they observe the controls but never influence fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallCount <= 32'd0;
            flushCount <= 32'd0;
        end else begin
            if (stall && (stallCount != 32'hFFFF_FFFF)) begin
                stallCount <= stallCount + 32'd1;
            end
            if ((flush || branchTakenFlag) && (flushCount != 32'hFFFF_FFFF)) begin
                flushCount <= flushCount + 32'd1;
            end
        end
    end
`else
    // No counters in this build; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences and
// randomized traffic against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, flush, branchTakenFlag;
    logic [31:0] branchTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_IFID, instr_IFID;
    logic        valid_IFID;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stallCount, flushCount;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    bit scramble    = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .flush          (flush),
        .branchTakenFlag(branchTakenFlag),
        .branchTarget   (branchTarget),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .pc_IFID        (pc_IFID),
        .instr_IFID     (instr_IFID),
        .valid_IFID     (valid_IFID)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stallCount     (stallCount),
        .flushCount     (flushCount)
`endif
    );

    // Behavioural model: "booting" flag, a queue holding at most one parked word.
    bit          mBoot;
    logic [31:0] mPc, mIfPc, mIfInstr;
    bit          mIfValid;
    logic [31:0] mSkid[$];

    typedef struct {
        logic        st;
        logic        fl;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expInstr;
        logic [31:0] expPc;
    } Vector;

    Vector vecs[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (scramble) return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
        return a;
    endfunction

    function automatic Vector mkVec(input logic st, input logic fl, input logic br,
                                    input logic [31:0] tgt, input logic rdy,
                                    input logic req, input logic [31:0] addr,
                                    input logic vld, input logic [31:0] ins,
                                    input logic [31:0] pcx);
        Vector v;
        v.st = st; v.fl = fl; v.br = br; v.tgt = tgt; v.rdy = rdy;
        v.expReq = req; v.expAddr = addr; v.expValid = vld;
        v.expInstr = ins; v.expPc = pcx;
        return v;
    endfunction

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic req, input logic [31:0] addr,
                               input logic vld, input logic [31:0] ins, input logic [31:0] pcx);
        checkOne($sformatf("%s imem_req", tag), {31'd0, imem_req}, {31'd0, req});
        checkOne($sformatf("%s imem_addr", tag), imem_addr, addr);
        checkOne($sformatf("%s valid_IFID", tag), {31'd0, valid_IFID}, {31'd0, vld});
        checkOne($sformatf("%s instr_IFID", tag), instr_IFID, ins);
        checkOne($sformatf("%s pc_IFID", tag), pc_IFID, pcx);
    endtask

    task automatic resetModel();
        mBoot    = 1'b1;
        mPc      = RESET_PC;
        mIfPc    = 32'd0;
        mIfInstr = NOP_INSTR;
        mIfValid = 1'b0;
        mSkid.delete();
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, !mBoot && (mSkid.size() == 0), mPc, mIfValid,
                    mIfValid ? mIfInstr : NOP_INSTR, mIfPc);
    endtask

    task automatic stepModel(input logic st, input logic fl, input logic br,
                             input logic [31:0] tgt, input logic rdy);
        if (br) begin
            mPc      = {tgt[31:2], 2'b00};
            mIfValid = 1'b0;
            mSkid.delete();
            mBoot    = 1'b0;
        end else if (fl) begin
            mIfValid = 1'b0;
            mSkid.delete();
            mBoot    = 1'b0;
        end else if (mBoot) begin
            mBoot = 1'b0;
        end else if (mSkid.size() != 0) begin
            if (!st) begin
                mIfPc    = mPc;
                mIfInstr = mSkid.pop_front();
                mIfValid = 1'b1;
                mPc      = mPc + 32'd4;
            end
        end else if (rdy && !st) begin
            mIfPc    = mPc;
            mIfInstr = memWord(mPc);
            mIfValid = 1'b1;
            mPc      = mPc + 32'd4;
        end else if (rdy) begin
            mSkid.push_back(memWord(mPc));
        end else if (!st) begin
            mIfValid = 1'b0;
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic st, input logic fl, input logic br,
                                 input logic [31:0] tgt, input logic rdy);
        stall           = st;
        flush           = fl;
        branchTakenFlag = br;
        branchTarget    = tgt;
        imem_ready      = rdy;
        imem_rdata      = memWord(imem_addr);
        @(posedge clk);
        stepModel(st, fl, br, tgt, rdy);
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n         = 1'b0;
        stall           = 1'b0;
        flush           = 1'b0;
        branchTakenFlag = 1'b0;
        branchTarget    = 32'd0;
        imem_ready      = 1'b0;
        imem_rdata      = 32'd0;
        #1;
        resetModel();
        checkModel("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n         = 1'b0;
        stall           = 1'b0;
        flush           = 1'b0;
        branchTakenFlag = 1'b0;
        branchTarget    = 32'd0;
        imem_ready      = 1'b0;
        imem_rdata      = 32'd0;

        //          st fl br target          rdy   req addr           vld instr         pc_IFID
        vecs.push_back(mkVec(0, 0, 0, 32'h0,         1,   1, 32'h0,         0, NOP_INSTR,    32'h0));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,         1,   1, 32'h4,         1, 32'h0,        32'h0));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,         1,   1, 32'h8,         1, 32'h4,        32'h4));
        vecs.push_back(mkVec(1, 0, 0, 32'h0,         1,   0, 32'h8,         1, 32'h4,        32'h4));
        vecs.push_back(mkVec(1, 0, 0, 32'h0,         1,   0, 32'h8,         1, 32'h4,        32'h4));
        vecs.push_back(mkVec(1, 0, 0, 32'h0,         0,   0, 32'h8,         1, 32'h4,        32'h4));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,         0,   1, 32'hC,         1, 32'h8,        32'h8));
        vecs.push_back(mkVec(0, 0, 1, 32'h103,       1,   1, 32'h100,       0, NOP_INSTR,    32'h8));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,         1,   1, 32'h104,       1, 32'h100,      32'h100));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,         0,   1, 32'h104,       0, NOP_INSTR,    32'h100));
        vecs.push_back(mkVec(1, 0, 0, 32'h0,         0,   1, 32'h104,       0, NOP_INSTR,    32'h100));
        vecs.push_back(mkVec(0, 1, 0, 32'h0,         1,   1, 32'h104,       0, NOP_INSTR,    32'h100));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,         1,   1, 32'h108,       1, 32'h104,      32'h104));
        vecs.push_back(mkVec(1, 0, 0, 32'h0,         1,   0, 32'h108,       1, 32'h104,      32'h104));
        vecs.push_back(mkVec(1, 0, 1, 32'h200,       1,   1, 32'h200,       0, NOP_INSTR,    32'h104));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,         1,   1, 32'h204,       1, 32'h200,      32'h200));
        vecs.push_back(mkVec(0, 0, 1, 32'hFFFF_FFFE, 1,   1, 32'hFFFF_FFFC, 0, NOP_INSTR,    32'h200));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,         1,   1, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,         1,   1, 32'h4,         1, 32'h0,        32'h0));

        doReset();
        checkOutput("boot", 1'b0, RESET_PC, 1'b0, NOP_INSTR, 32'h0);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].st, vecs[i].fl, vecs[i].br, vecs[i].tgt, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr,
                        vecs[i].expValid, vecs[i].expInstr, vecs[i].expPc);
        end

        // Asynchronous reset while a word sits in the skid register.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 32'h0, 1);
            checkModel($sformatf("pre-hold%0d", i));
        end
        applyStimulus(1, 0, 0, 32'h0, 1);
        checkModel("hold-enter");
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async-reset", 1'b0, RESET_PC, 1'b0, NOP_INSTR, 32'h0);
        resetModel();
        @(negedge clk);
        stall   = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 32'h0, 1);
            checkModel($sformatf("post-reset%0d", i));
        end

        // Flush while holding: the parked word is dropped and its address refetched.
        applyStimulus(1, 0, 0, 32'h0, 1);
        applyStimulus(1, 1, 0, 32'h0, 1);
        checkModel("hold-flush");
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkModel("refetch");

        // Randomized traffic with a scrambled memory image.
        scramble = 1'b1;
        doReset();
        for (int i = 0; i < 400; i++) begin
            logic        st, fl, br, rdy;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            br  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                              : 32'($urandom);
            applyStimulus(st, fl, br, tgt, rdy);
            checkModel($sformatf("rand%0d", i));
        end

`ifdef FETCH_PERF_CNT_EN
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOne("stallCount", stallCount, 32'd5);
        checkOne("flushCount", flushCount, 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        checkOne("stallCount-reset", stallCount, 32'd0);
        checkOne("flushCount-reset", flushCount, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
